// File: rtl/spi_shift_engine.sv
// rtl/spi_shift_engine.sv - byte-wide SPI master shift engine driven by the divider's half-period timebase
// One transfer per start level: CS setup tick, 2*DATA_W SCK edges, CS hold tick, then a level done flag.
module spi_shift_engine #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_div,
  input  logic              start,
  input  logic [1:0]        dir,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              tx_ok,
  output logic              rx_ok,
  output logic              rtx_ok,
  output logic              spi_sck,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic              spi_cs_n
);

  localparam int CW = $clog2(2 * DATA_W) + 1;
  localparam logic [CW-1:0] LAST_EDGE = CW'(2 * DATA_W);

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    XFER,
    TRAIL,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic              clk_div_q;
  logic              tick;
  logic [1:0]        dir_q;
  logic              cpha_q;
  logic              lsb_q;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-1:0] rx_sh;
  logic [CW-1:0]     edge_cnt;
  logic [CW-1:0]     edge_nxt;
  logic              leading;
  logic              sample_now;
  logic              shift_now;
  logic              launch;

  function automatic logic first_bit(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? v[0] : v[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] drop_bit(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? (v >> 1) : (v << 1);
  endfunction

  function automatic logic [DATA_W-1:0] push_bit(input logic [DATA_W-1:0] v, input logic b,
                                                 input logic lsb);
    return lsb ? {b, v[DATA_W-1:1]} : {v[DATA_W-2:0], b};
  endfunction

  assign tick     = clk_div ^ clk_div_q;
  assign busy     = (state != IDLE);
  assign launch   = start && (dir != 2'b00);
  assign edge_nxt = edge_cnt + 1'b1;
  assign leading  = edge_nxt[0];

  // Sample edge is leading for cpha=0 and trailing for cpha=1; the other edge shifts MOSI.
  // With cpha=0 the final trailing edge has no further bit to launch.
  assign sample_now = (state == XFER) && tick && (leading ^ cpha_q);
  assign shift_now  = (state == XFER) && tick && !(leading ^ cpha_q) &&
                      (cpha_q || (edge_nxt != LAST_EDGE));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (launch) state_nxt = LEAD;
      LEAD:    if (tick) state_nxt = XFER;
      XFER:    if (tick && (edge_nxt == LAST_EDGE)) state_nxt = TRAIL;
      TRAIL:   if (tick) state_nxt = DONE;
      DONE:    if (!start) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      clk_div_q <= 1'b0;
      dir_q     <= 2'b00;
      cpha_q    <= 1'b0;
      lsb_q     <= 1'b0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      edge_cnt  <= '0;
      rx_data   <= '0;
      tx_ok     <= 1'b0;
      rx_ok     <= 1'b0;
      rtx_ok    <= 1'b0;
      spi_sck   <= 1'b0;
      spi_mosi  <= 1'b1;
      spi_cs_n  <= 1'b1;
    end else begin
      state     <= state_nxt;
      clk_div_q <= clk_div;
      case (state)
        IDLE: begin
          spi_sck  <= cpol;
          spi_cs_n <= 1'b1;
          spi_mosi <= 1'b1;
          if (launch) begin
            dir_q    <= dir;
            cpha_q   <= cpha;
            lsb_q    <= lsb_first;
            edge_cnt <= '0;
            rx_sh    <= '0;
            spi_cs_n <= 1'b0;
            if (!cpha && dir[0]) begin
              spi_mosi <= first_bit(tx_data, lsb_first);
              tx_sh    <= drop_bit(tx_data, lsb_first);
            end else begin
              tx_sh <= tx_data;
            end
          end
        end
        LEAD: begin
        end
        XFER: begin
          if (tick) begin
            spi_sck  <= ~spi_sck;
            edge_cnt <= edge_nxt;
          end
          if (sample_now && dir_q[1]) rx_sh <= push_bit(rx_sh, spi_miso, lsb_q);
          if (shift_now && dir_q[0]) begin
            spi_mosi <= first_bit(tx_sh, lsb_q);
            tx_sh    <= drop_bit(tx_sh, lsb_q);
          end
        end
        TRAIL: begin
          if (tick) begin
            spi_cs_n <= 1'b1;
            if (dir_q[1]) rx_data <= rx_sh;
            tx_ok  <= (dir_q == 2'b01);
            rx_ok  <= (dir_q == 2'b10);
            rtx_ok <= (dir_q == 2'b11);
          end
        end
        DONE: begin
          if (!start) begin
            tx_ok  <= 1'b0;
            rx_ok  <= 1'b0;
            rtx_ok <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_shift_engine.sv
// tb/tb_spi_shift_engine.sv - scoreboard bench for spi_shift_engine with an SPI slave/wire model
// Stimulus pushes expected results; a negedge monitor watches the bus and checks on each done flag.
module tb_spi_shift_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk_div = 1'b0;
  logic       start = 1'b0;
  logic [1:0] dir = 2'b00;
  logic       cpol = 1'b0;
  logic       cpha = 1'b0;
  logic       lsb_first = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] rx_data;
  logic       busy, tx_ok, rx_ok, rtx_ok;
  logic       spi_sck, spi_mosi, spi_miso, spi_cs_n;

  spi_shift_engine #(.DATA_W(8)) dut (
    .clk(clk), .rst(rst), .clk_div(clk_div), .start(start), .dir(dir),
    .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .tx_data(tx_data),
    .rx_data(rx_data), .busy(busy), .tx_ok(tx_ok), .rx_ok(rx_ok), .rtx_ok(rtx_ok),
    .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_cs_n(spi_cs_n)
  );

  always #5 clk = ~clk;

  int div_cnt = 0;
  always @(posedge clk) begin
    if (div_cnt == 3) begin
      div_cnt <= 0;
      clk_div <= ~clk_div;
    end else begin
      div_cnt <= div_cnt + 1;
    end
  end

  logic loopback = 1'b0;
  logic miso_drv = 1'b1;
  assign spi_miso = loopback ? spi_mosi : miso_drv;

  typedef struct {
    logic [2:0] flags;
    logic [7:0] rx;
    logic [7:0] mosi_seq;
    logic       mosi_ones;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  logic       cur_cpol = 1'b0, cur_cpha = 1'b0, cur_lsb = 1'b0;
  logic [7:0] slave_byte = 8'h00;
  logic [7:0] rx_model = 8'h00;

  logic       sck_prev = 1'b0, cs_prev = 1'b1, div_prev = 1'b0;
  logic [2:0] flags_prev = 3'b000;
  logic [7:0] mosi_seq = 8'h00;
  logic       mosi_ones = 1'b1;
  int         edges = 0, ticks = 0, nbits = 0, sl_idx = 0, cs_falls = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic bit_of(input logic [7:0] b, input int i, input logic lsb);
    return lsb ? b[i] : b[7-i];
  endfunction

  function automatic logic [2:0] flag_vec();
    return {rtx_ok, rx_ok, tx_ok};
  endfunction

  // Bus monitor and slave: counts edges/ticks under CS, records MOSI at sample edges, drives MISO.
  always @(negedge clk) begin
    logic [2:0] fl;
    logic       lead;
    exp_t       e;
    fl = flag_vec();
    if (cs_prev && !spi_cs_n) begin
      cs_falls++;
      edges = 0; ticks = 0; nbits = 0; sl_idx = 0;
      mosi_seq = 8'h00; mosi_ones = 1'b1;
      miso_drv = cur_cpha ? 1'b1 : bit_of(slave_byte, 0, cur_lsb);
    end
    if (!spi_cs_n) begin
      if (clk_div != div_prev) ticks++;
      if (!spi_mosi) mosi_ones = 1'b0;
      if (spi_sck != sck_prev) begin
        edges++;
        lead = (spi_sck != cur_cpol);
        if (lead ^ cur_cpha) begin
          if (nbits < 8) mosi_seq[7-nbits] = spi_mosi;
          nbits++;
        end else if (cur_cpha) begin
          if (sl_idx < 8) miso_drv = bit_of(slave_byte, sl_idx, cur_lsb);
          sl_idx++;
        end else begin
          sl_idx++;
          if (sl_idx < 8) miso_drv = bit_of(slave_byte, sl_idx, cur_lsb);
        end
      end
    end
    if (fl != 3'b000 && flags_prev == 3'b000) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got flags %0b expected no transfer", fl);
      end else begin
        e = sb.pop_front();
        check("done_flags", fl, e.flags);
        check("rx_data", rx_data, e.rx);
        check("mosi_bits", mosi_seq, e.mosi_seq);
        check("mosi_const", mosi_ones, e.mosi_ones);
        check("sck_edges", edges, 16);
        check("cs_low_ticks", ticks, 18);
        check("sck_end_level", spi_sck, cur_cpol);
        check("cs_high_at_done", spi_cs_n, 1'b1);
      end
    end
    flags_prev = fl;
    sck_prev   = spi_sck;
    cs_prev    = spi_cs_n;
    div_prev   = clk_div;
  end

  task automatic do_xfer(input logic [1:0] d, input logic c_pol, input logic c_pha,
                         input logic lsbf, input logic [7:0] tx, input logic [7:0] sl,
                         input logic lb, input int hold);
    exp_t       e;
    logic [2:0] ef;
    int         n;
    int         falls0;
    @(negedge clk);
    cur_cpol = c_pol; cur_cpha = c_pha; cur_lsb = lsbf;
    cpol = c_pol; cpha = c_pha; lsb_first = lsbf; dir = d; tx_data = tx;
    slave_byte = sl; loopback = lb;
    repeat (3) @(negedge clk);
    check("sck_idle", spi_sck, c_pol);
    ef = (d == 2'b01) ? 3'b001 : (d == 2'b10) ? 3'b010 : 3'b100;
    if (d[1]) rx_model = lb ? (d[0] ? tx : 8'hFF) : sl;
    e.flags = ef;
    e.rx    = rx_model;
    for (int i = 0; i < 8; i++) e.mosi_seq[7-i] = d[0] ? bit_of(tx, i, lsbf) : 1'b1;
    e.mosi_ones = (d == 2'b10) || (tx == 8'hFF);
    sb.push_back(e);
    start = 1'b1;
    @(negedge clk);
    check("cs_fall_latency", spi_cs_n, 1'b0);
    check("busy_active", busy, 1'b1);
    tx_data = 8'($urandom); dir = 2'($urandom);
    cpol = 1'($urandom); cpha = 1'($urandom); lsb_first = 1'($urandom);
    n = 0;
    while (flag_vec() == 3'b000 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no flag after %0d clk expected flag %0b", n, ef);
      sb.delete();
    end
    falls0 = cs_falls;
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      check("flag_hold", flag_vec(), ef);
      check("no_retrigger", cs_falls - falls0, 0);
    end
    start = 1'b0;
    @(negedge clk);
    check("flag_clear", flag_vec(), 3'b000);
    check("busy_idle", busy, 1'b0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int falls0;
    repeat (3) @(negedge clk);
    check("rst_rx_data", rx_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_flags", flag_vec(), 3'b000);
    check("rst_sck", spi_sck, 1'b0);
    check("rst_mosi", spi_mosi, 1'b1);
    check("rst_cs_n", spi_cs_n, 1'b1);
    rst = 1'b0;

    // Abort mid-transfer at SCK edge 7 while MOSI is driving a 0 bit.
    @(negedge clk);
    cur_cpol = 1'b0; cur_cpha = 1'b0; cur_lsb = 1'b0;
    cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; dir = 2'b11; tx_data = 8'h0F;
    loopback = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b1;
    n = 0;
    while (!(edges >= 7 && !spi_cs_n) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("abort_reached_edge7", edges, 7);
    rst = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check("abort_cs_n", spi_cs_n, 1'b1);
    check("abort_sck", spi_sck, 1'b0);
    check("abort_mosi", spi_mosi, 1'b1);
    check("abort_busy", busy, 1'b0);
    check("abort_flags", flag_vec(), 3'b000);
    check("abort_rx_data", rx_data, rx_model);
    rst = 1'b0;

    // Invalid direction is ignored.
    @(negedge clk);
    falls0 = cs_falls;
    dir = 2'b00;
    start = 1'b1;
    repeat (20) @(negedge clk);
    check("dir00_no_cs", cs_falls - falls0, 0);
    check("dir00_cs_n", spi_cs_n, 1'b1);
    check("dir00_busy", busy, 1'b0);
    check("dir00_flags", flag_vec(), 3'b000);
    start = 1'b0;

    do_xfer(2'b11, 1'b0, 1'b0, 1'b0, 8'hA5, 8'h00, 1'b1, 0);
    do_xfer(2'b01, 1'b1, 1'b1, 1'b1, 8'h81, 8'h5A, 1'b0, 0);
    do_xfer(2'b10, 1'b0, 1'b1, 1'b0, 8'h00, 8'h3C, 1'b0, 0);
    do_xfer(2'b11, 1'b1, 1'b0, 1'b1, 8'h6E, 8'h00, 1'b1, 50);

    for (int k = 0; k < 12; k++) begin
      do_xfer(2'($urandom_range(1, 3)), 1'($urandom), 1'($urandom), 1'($urandom),
              8'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 3));
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
